muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Issue and write-back bundle between the decode/register-file side and muldiv_unit.
interface muldiv_unit_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGISTERS = 16
);
  localparam int AW = $clog2(NUM_REGISTERS);

  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [AW-1:0]         rd_addr;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] wd3;
  logic [AW-1:0]         wa3;
  logic                  we3;

  modport master (output start, op, a, b, rd_addr,
                  input  busy, done, wd3, wa3, we3);
  modport slave  (input  start, op, a, b, rd_addr,
                  output busy, done, wd3, wa3, we3);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle unsigned multiply / restoring divide unit.
// The result is registered onto the register-file write port for exactly one cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGISTERS = 16
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int AW = $clog2(NUM_REGISTERS);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
  } req_t;

  state_t        state, nxt;
  req_t          req;
  logic [2*W-1:0] prod;
  logic [W:0]     rem;
  logic [W-1:0]   quo;
  logic [CW-1:0]  cnt;

  logic [W-1:0]  wd3_q;
  logic [AW-1:0] wa3_q;
  logic          we3_q, done_q;

  logic [W:0]     psum, rsh, rdiff, rem_nx;
  logic [2*W-1:0] prod_nx;
  logic [W-1:0]   quo_nx, res;
  logic           div0, last;

  // Multiply: high half accumulates the multiplicand, low half shifts the multiplier out.
  always_comb begin
    psum    = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, req.a} : {(W+1){1'b0}});
    prod_nx = {psum, prod[W-1:1]};
  end

  // Restoring divide: dividend bits shift MSB-first out of quo while quotient bits shift in.
  always_comb begin
    rsh    = {rem[W-1:0], quo[W-1]};
    rdiff  = rsh - {1'b0, req.b};
    rem_nx = rdiff[W] ? rsh : rdiff;
    quo_nx = {quo[W-2:0], ~rdiff[W]};
  end

  // Divide-by-zero is forced explicitly so it never depends on the iteration details.
  always_comb begin
    div0 = (req.b == '0);
    res  = '0;
    case (req.op)
      OP_MUL:   res = prod_nx[W-1:0];
      OP_MULHU: res = prod_nx[2*W-1:W];
      OP_DIVU:  res = div0 ? {W{1'b1}} : quo_nx;
      OP_REMU:  res = div0 ? req.a : rem_nx[W-1:0];
      default:  res = '0;
    endcase
  end

  assign last = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (cnt == CW'(1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req    <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      wd3_q  <= '0;
      wa3_q  <= '0;
      we3_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we3_q  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          req  <= '{op: bus.op, a: bus.a, b: bus.b, rd: bus.rd_addr};
          prod <= {{W{1'b0}}, bus.b};
          rem  <= '0;
          quo  <= bus.a;
          cnt  <= CW'(W);
        end
        RUN: begin
          prod <= prod_nx;
          rem  <= rem_nx;
          quo  <= quo_nx;
          cnt  <= cnt - CW'(1);
          if (last) begin
            done_q <= 1'b1;
            we3_q  <= (req.rd != '0);
            wd3_q  <= res;
            wa3_q  <= req.rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.we3  = we3_q;
  assign bus.wd3  = wd3_q;
  assign bus.wa3  = wa3_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected write-backs are queued at issue and popped on done.
module tb_muldiv_unit;
  localparam int DW = 16;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) bus ();
  muldiv_unit #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] wd;
    logic [3:0]  wa;
    logic        we;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every done pops one expectation; a write enable outside done is always wrong.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (q.size() == 0) chk("sb_unexpected_done", 32'(1), 32'(0));
      else begin
        e = q.pop_front();
        chk("wd3", 32'(bus.wd3), 32'(e.wd));
        chk("wa3", 32'(bus.wa3), 32'(e.wa));
        chk("we3", 32'(bus.we3), 32'(e.we));
      end
    end
    if (bus.we3 && !bus.done) chk("we3_stray", 32'(1), 32'(0));
  end

  task automatic run(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] rd, input logic [15:0] exp, input bit noise);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    chk("idle_before_issue", 32'(bus.busy), 32'(0));
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_addr = rd;
    q.push_back('{wd: exp, wa: rd, we: (rd != 4'd0)});
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      lat = c;
      if (bus.busy) bcnt++;
      bus.start = noise && (c == 5);
      if (noise) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.op = 2'($urandom); bus.rd_addr = 4'($urandom);
      end
      if (bus.done) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("latency", 32'(lat), 32'(17));
    chk("busy_cycles", 32'(bcnt), 32'(17));
    if (noise) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_in_done_ignored", 32'(bus.busy), 32'(0));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_we3",  32'(bus.we3),  32'(0));
    chk("rst_wd3",  32'(bus.wd3),  32'(0));
    chk("rst_wa3",  32'(bus.wa3),  32'(0));
    rst = 1'b1;

    run(2'b00, 16'd300,  16'd200,  4'd3, 16'hEA60, 1'b0);
    run(2'b01, 16'h1234, 16'h5678, 4'd5, 16'h0626, 1'b0);
    run(2'b00, 16'h1234, 16'h5678, 4'd5, 16'h0060, 1'b0);
    run(2'b10, 16'd1000, 16'd7,    4'd7, 16'h008E, 1'b0);
    run(2'b11, 16'd1000, 16'd7,    4'd7, 16'h0006, 1'b0);
    run(2'b10, 16'h1234, 16'h0000, 4'd4, 16'hFFFF, 1'b0);
    run(2'b11, 16'h1234, 16'h0000, 4'd4, 16'h1234, 1'b0);
    run(2'b00, 16'd5,    16'd5,    4'd0, 16'd25,   1'b0);
    run(2'b01, 16'hFFFF, 16'hFFFF, 4'd10, 16'hFFFE, 1'b1);

    // Abort a divide with reset at RUN cycle 8; nothing may be written afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 16'd1000; bus.b = 16'd7; bus.rd_addr = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    chk("abort_we3",  32'(bus.we3),  32'(0));
    chk("abort_wd3",  32'(bus.wd3),  32'(0));
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'(0));
    run(2'b10, 16'd1000, 16'd7, 4'd9, 16'h008E, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  op;
      logic [15:0] a, b;
      logic [3:0]  rd;
      op = 2'(i % 4);
      a  = 16'($urandom);
      b  = (i % 2 == 1) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      rd = 4'($urandom_range(1, 15));
      run(op, a, b, rd, model(op, a, b), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
